// File: rtl/mole_controller.sv
// rtl/mole_controller.sv - whack-a-mole round sequencer (mole select, up/gap timing, hit/miss pulses)
//
// Lights one pseudo-randomly chosen mole at a time, times its up-window and
// detects the player's rising button edge on the lit mole.
// Optional feature macro: MOLE_WRONG_PENALTY_EN (a wrong-button edge ends the
// round with a miss; when undefined wrong-button edges are ignored).
//
// Ports:
//   clk       - system clock, rising edge
//   restart   - asynchronous active-high reset
//   enable    - game running; low parks the block in IDLE
//   buttons   - debounced, synchronised button levels (1 = pressed)
//   mole_leds - one-hot lit mole while in UP, else zero
//   mole_hit  - one-cycle pulse on a successful hit
//   mole_miss - one-cycle pulse when a round ends without a hit
module mole_controller #(
  parameter int          NUM_MOLES  = 4,
  parameter int          UP_CYCLES  = 50_000_000,
  parameter int          GAP_CYCLES = 25_000_000,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 restart,
  input  logic                 enable,
  input  logic [NUM_MOLES-1:0] buttons,
  output logic [NUM_MOLES-1:0] mole_leds,
  output logic                 mole_hit,
  output logic                 mole_miss
);

  localparam int SEL_W   = $clog2(NUM_MOLES);
  localparam int MAX_CYC = (UP_CYCLES > GAP_CYCLES) ? UP_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // An all-zero LFSR would lock up, so a zero seed is forced to 1.
  localparam logic [15:0]      SEED     = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] UP_LAST  = CNT_W'(UP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    UP   = 2'd2
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [NUM_MOLES-1:0] btn_prev;
  logic [15:0]          lfsr;
  logic [SEL_W-1:0]     sel;

  logic [NUM_MOLES-1:0] btn_edge;
  logic                 lfsr_fb;
  logic                 hit_now;
  logic                 wrong_now;

  // Only rising edges count, so a button already held when the mole lights
  // must be released and pressed again.
  assign btn_edge = buttons & ~btn_prev;

  // Fibonacci LFSR, taps 16,14,13,11.
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  assign hit_now = btn_edge[sel];

`ifdef MOLE_WRONG_PENALTY_EN
  // Any edge off the lit mole ends the round, unless the lit mole also rose.
  assign wrong_now = ~hit_now & (|(btn_edge & ~(NUM_MOLES'(1) << sel)));
`else
  assign wrong_now = 1'b0;
`endif

  always_ff @(posedge clk or posedge restart) begin
    if (restart) begin
      state     <= IDLE;
      cnt       <= '0;
      btn_prev  <= '0;
      lfsr      <= SEED;
      sel       <= '0;
      mole_leds <= '0;
      mole_hit  <= 1'b0;
      mole_miss <= 1'b0;
    end else begin
      btn_prev  <= buttons;
      lfsr      <= {lfsr[14:0], lfsr_fb};
      mole_hit  <= 1'b0;
      mole_miss <= 1'b0;

      if (!enable) begin
        // Abandon any round silently.
        state     <= IDLE;
        cnt       <= '0;
        mole_leds <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= GAP;
            cnt   <= '0;
          end

          GAP: begin
            if (cnt == GAP_LAST) begin
              state     <= UP;
              cnt       <= '0;
              sel       <= lfsr[SEL_W-1:0];
              mole_leds <= NUM_MOLES'(1) << lfsr[SEL_W-1:0];
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end

          UP: begin
            // Hit takes priority over the timeout on the final UP cycle.
            if (hit_now) begin
              state     <= GAP;
              cnt       <= '0;
              mole_leds <= '0;
              mole_hit  <= 1'b1;
            end else if (wrong_now || (cnt == UP_LAST)) begin
              state     <= GAP;
              cnt       <= '0;
              mole_leds <= '0;
              mole_miss <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end

          default: begin
            state     <= IDLE;
            cnt       <= '0;
            mole_leds <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/mole_controller.md
# mole_controller

Round sequencer for the whack-a-mole game, upstream of the score counter. Pops one pseudo-randomly chosen mole LED at a time, times the up-window, and detects the player's button press. Emits the single-cycle `mole_hit` pulse that drives the score counter's `mole_hit` input, plus a `mole_miss` pulse for status logic.

## Interface
- `NUM_MOLES`, default 4: number of moles/buttons; power of two, 2..16.
- `UP_CYCLES`, default 50_000_000: cycles a mole stays lit; must be ≥1.
- `GAP_CYCLES`, default 25_000_000: dark cycles between moles; must be ≥1.
- `LFSR_SEED`, default 16'hACE1: 16-bit LFSR reset value; 0 is replaced by 1.
- `clk` in 1: system clock; all logic on its rising edge.
- `restart` in 1: reset, asynchronous, active-high.
- `enable` in 1: game running; low parks the block in IDLE.
- `buttons` in NUM_MOLES: debounced, synchronised button levels; 1 = pressed.
- `mole_leds` out NUM_MOLES: one-hot lit mole in UP, else all zero.
- `mole_hit` out 1: one-cycle pulse on a successful hit.
- `mole_miss` out 1: one-cycle pulse when a round ends without a hit.

## Operation
- Reset values: state IDLE, `mole_leds`=0, `mole_hit`=0, `mole_miss`=0, counter=0, `btn_prev`=0, LFSR=`LFSR_SEED`.
- All outputs registered. `btn_prev` registers `buttons` every cycle. `edge = buttons & ~btn_prev`, rising edges only.
- 16-bit Fibonacci LFSR, taps 16,14,13,11, advances every cycle in all states.
- States:
  - IDLE: `enable`=1 → GAP, counter cleared.
  - GAP: counts `GAP_CYCLES` cycles. On the last one: → UP, `sel = lfsr[log2(NUM_MOLES)-1:0]`, `mole_leds = 1<<sel`, counter cleared.
  - UP: if `edge[sel]`=1 → `mole_hit`=1, `mole_leds`=0, → GAP. Else, on the `UP_CYCLES`-th UP cycle → `mole_miss`=1, `mole_leds`=0, → GAP.
- Hit on the final UP cycle: hit wins, no `mole_miss`.
- Multiple simultaneous edges that include `sel`: counts as a hit.
- Button already held when the mole lights: no edge, so no hit. The player must release and re-press.
- `enable` low in any state: next edge → IDLE, `mole_leds`=0, counter cleared, no pulse. A round in progress is abandoned silently.
- `restart` asserted at any time: immediate return to reset values, no pulse.
- Counter width: `$clog2(max(UP_CYCLES,GAP_CYCLES)+1)`. No wrap occurs, because the count is compared and cleared at the terminal value.

## Timing
- A button rising before posedge k, while in UP with that mole lit, gives `mole_hit` high for the cycle after posedge k. `mole_leds` clears on the same edge. Latency is 1 cycle.
- A mole is lit for exactly `UP_CYCLES` cycles if not hit.
- Gap is exactly `GAP_CYCLES` dark cycles between rounds, and between IDLE exit and the first mole.
- `mole_hit` and `mole_miss` are never both high. Each is high for at most one cycle per round.
- Minimum spacing between pulses is `GAP_CYCLES+1` cycles.

## Configuration
- `MOLE_WRONG_PENALTY_EN` defined: in UP, a rising edge on any non-`sel` button with no edge on `sel` ends the round. Response: `mole_miss`=1, `mole_leds`=0, → GAP, same cycle timing as a hit.
- Undefined: wrong-button edges are ignored and the round continues to hit or timeout.

## Test plan
All scenarios use `NUM_MOLES`=4, `UP_CYCLES`=8, `GAP_CYCLES`=4, `LFSR_SEED`=16'hACE1.
- Reset: assert `restart` mid-UP → `mole_leds`=0, `mole_hit`=`mole_miss`=0 before the next clock edge. Hold `enable`=1 and release → 4 dark cycles, then a mole lights.
- Timeout: `enable`=1, no buttons → one-hot LEDs for exactly 8 cycles, one `mole_miss` pulse, 4 dark cycles, next mole. Mole index matches the reference LFSR model.
- Hit: press the lit button on UP cycle 3 → `mole_hit` high exactly 1 cycle, LEDs 0 from the same edge, no `mole_miss`. A score counter attached increments by 1.
- Held button and boundary: hold the target button from GAP into UP → no hit, `mole_miss` at cycle 8. Separately, an edge on UP cycle 8 → `mole_hit`=1, `mole_miss`=0.
- Wrong button: edge on a non-lit button on UP cycle 2. Macro defined → `mole_miss` pulse, round ends. Macro undefined → no pulse, LEDs stay lit until timeout.
- Enable drop: deassert `enable` on UP cycle 5 → IDLE next cycle, LEDs 0, no pulses. Re-enable → 4-cycle gap, then a new round.
